// File: rtl/mirfak_defines_pkg.sv
// Shared definitions for the Mirfak Wishbone RAM slave: FSM encodings and wait-counter width.
package mirfak_defines;

    typedef enum logic [1:0] {
        WB_RAM_IDLE = 2'd0,
        WB_RAM_WAIT = 2'd1,
        WB_RAM_RESP = 2'd2
    } wb_ram_state_e;

    localparam int unsigned WB_RAM_CNT_W = 4;

endpackage

// File: rtl/mirfak_wb_ram_array.sv
// Word-organised synchronous RAM with byte write enables and a registered read port.
module mirfak_wb_ram_array #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter string       MEMFILE    = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Output register holds the last read word until the next read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mirfak_wb_ram_slave.sv
// Wishbone classic slave RAM with programmable wait states.
// Define MIRFAK_WB_RAM_RANGE_CHECK_EN to answer out-of-range addresses with err instead of aliasing.
module mirfak_wb_ram_slave
    import mirfak_defines::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam logic [WB_RAM_CNT_W-1:0] WaitLoad =
        (WAIT_STATES > 0) ? WB_RAM_CNT_W'(WAIT_STATES - 1) : '0;

    wb_ram_state_e             state_q, state_d;
    logic [WB_RAM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic                      req;
    logic                      in_range;
    logic                      go_resp;
    logic                      ram_we;
    logic                      ram_re;
    logic                      unused_addr;

    assign req = wbs_cyc_i && wbs_stb_i;

`ifdef MIRFAK_WB_RAM_RANGE_CHECK_EN
    assign in_range    = (wbs_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign unused_addr = ^wbs_addr_i[1:0];
`else
    assign in_range    = 1'b1;
    assign unused_addr = ^{wbs_addr_i[31:ADDR_WIDTH+2], wbs_addr_i[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        unique case (state_q)
            WB_RAM_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = WB_RAM_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WB_RAM_WAIT;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            WB_RAM_WAIT: begin
                if (!req) begin
                    state_d = WB_RAM_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = WB_RAM_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WB_RAM_RESP: begin
                // The request still visible here belongs to the completing transfer.
                state_d = WB_RAM_IDLE;
            end
            default: begin
                state_d = WB_RAM_IDLE;
            end
        endcase
    end

    always_comb begin
        ack_d = go_resp && in_range;
        err_d = go_resp && !in_range;
    end

    // A reset at the access edge must suppress the write as well as the response.
    assign ram_we = go_resp && in_range && wbs_we_i && rst_ni;
    assign ram_re = go_resp && in_range && !wbs_we_i && rst_ni;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= WB_RAM_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    mirfak_wb_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEMFILE    ("")
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (ram_we),
        .be_i    (wbs_sel_i),
        .addr_i  (wbs_addr_i[ADDR_WIDTH+1:2]),
        .wdata_i (wbs_dat_i),
        .re_i    (ram_re),
        .rdata_o (wbs_dat_o)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;

endmodule

// File: tb/tb_mirfak_wb_ram_slave.sv
// Directed bench for mirfak_wb_ram_slave: one instance with no wait states, one with three.
module tb_mirfak_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc_a;
    logic        cyc_b;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b;
    logic        err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack_a = 0, n_ack_b = 0, n_err_a = 0, n_err_b = 0, n_both = 0;

    always #5 clk = ~clk;

    mirfak_wb_ram_slave #(
        .ADDR_WIDTH  (10),
        .BASE_ADDR   (32'h8000_0000),
        .WAIT_STATES (0)
    ) u_dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wbs_addr_i (addr),
        .wbs_dat_i  (wdat),
        .wbs_sel_i  (sel),
        .wbs_cyc_i  (cyc_a),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_dat_o  (dat_a),
        .wbs_ack_o  (ack_a),
        .wbs_err_o  (err_a)
    );

    mirfak_wb_ram_slave #(
        .ADDR_WIDTH  (10),
        .BASE_ADDR   (32'h8000_0000),
        .WAIT_STATES (3)
    ) u_dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wbs_addr_i (addr),
        .wbs_dat_i  (wdat),
        .wbs_sel_i  (sel),
        .wbs_cyc_i  (cyc_b),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_dat_o  (dat_b),
        .wbs_ack_o  (ack_b),
        .wbs_err_o  (err_b)
    );

    // Every response cycle is tallied so widened or spurious acks show up in the totals.
    always @(negedge clk) begin
        if (ack_a) n_ack_a <= n_ack_a + 1;
        if (ack_b) n_ack_b <= n_ack_b + 1;
        if (err_a) n_err_a <= n_err_a + 1;
        if (err_b) n_err_b <= n_err_b + 1;
        if ((ack_a && err_a) || (ack_b && err_b)) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns one cycle after the response has gone.
    task automatic access(input string tag, input logic use_b, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic exp_ack, input logic exp_err, input int exp_cyc,
                          input logic [31:0] exp_dat);
        int   ncyc;
        logic gack, gerr, tail;
        logic [31:0] rd;
        addr  = a;
        wdat  = d;
        sel   = s;
        we    = w;
        stb   = 1'b1;
        cyc_a = !use_b;
        cyc_b = use_b;
        ncyc  = 0;
        gack  = 1'b0;
        gerr  = 1'b0;
        while (!(gack || gerr) && ncyc < 20) begin
            @(posedge clk);
            #1;
            ncyc++;
            gack = use_b ? ack_b : ack_a;
            gerr = use_b ? err_b : err_a;
        end
        rd = use_b ? dat_b : dat_a;
        chk({tag, "_ack"}, 32'(gack), 32'(exp_ack));
        chk({tag, "_err"}, 32'(gerr), 32'(exp_err));
        chk({tag, "_lat"}, 32'(ncyc), 32'(exp_cyc));
        chk({tag, "_dat"}, rd, exp_dat);
        @(posedge clk);
        #1;
        tail = use_b ? (ack_b || err_b) : (ack_a || err_a);
        chk({tag, "_tail"}, 32'(tail), 32'd0);
        stb   = 1'b0;
        cyc_a = 1'b0;
        cyc_b = 1'b0;
    endtask

    logic [31:0] b2b_dat [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};

    initial begin
        int base_ack_b;
        rst_n = 1'b0;
        addr  = '0;
        wdat  = '0;
        sel   = '0;
        we    = 1'b0;
        stb   = 1'b0;
        cyc_a = 1'b0;
        cyc_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_dat_a", dat_a, 32'd0);
        chk("rst_dat_b", dat_b, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write then read, zero wait states
        access("w_single", 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1, 0, 1, 32'h0);
        access("r_single", 1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 1, 0, 1, 32'hDEAD_BEEF);

        // Byte lanes
        access("w_full", 1'b0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 1, 0, 1, 32'hDEAD_BEEF);
        access("w_lane2", 1'b0, 1'b1, 32'h8000_0020, 32'hAAAA_AAAA, 4'b0100, 1, 0, 1,
               32'hDEAD_BEEF);
        access("r_lane2", 1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'hF, 1, 0, 1, 32'h11AA_3344);
        access("w_hi", 1'b0, 1'b1, 32'h8000_0020, 32'h5566_0000, 4'b1100, 1, 0, 1, 32'h11AA_3344);
        access("r_hi", 1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'b0001, 1, 0, 1, 32'h5566_3344);

        // Three wait states
        access("w_ws3", 1'b1, 1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 1, 0, 4, 32'h0);
        access("r_ws3", 1'b1, 1'b0, 32'h8000_0030, 32'h0, 4'hF, 1, 0, 4, 32'hCAFE_F00D);

        // Abort during WAIT: request dropped in the second cycle
        base_ack_b = n_ack_b;
        addr  = 32'h8000_0030;
        wdat  = 32'h0BAD_BAD0;
        sel   = 4'hF;
        we    = 1'b1;
        stb   = 1'b1;
        cyc_b = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        stb   = 1'b0;
        cyc_b = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("abort_noack", 32'(n_ack_b - base_ack_b), 32'd0);
        access("r_abort", 1'b1, 1'b0, 32'h8000_0030, 32'h0, 4'hF, 1, 0, 4, 32'hCAFE_F00D);

        // Back-to-back writes then reads
        for (int i = 0; i < 4; i++) begin
            access("b2b_w", 1'b0, 1'b1, 32'h8000_0100 + 32'(4 * i), b2b_dat[i], 4'hF, 1, 0, 1,
                   32'h5566_3344);
        end
        for (int i = 0; i < 4; i++) begin
            access("b2b_r", 1'b0, 1'b0, 32'h8000_0100 + 32'(4 * i), 32'h0, 4'hF, 1, 0, 1,
                   b2b_dat[i]);
        end

        // Out-of-range access: 0x4000_0040 aliases word 0x10
        access("w_base", 1'b0, 1'b1, 32'h8000_0040, 32'h5A5A_5A5A, 4'hF, 1, 0, 1, 32'h7654_3210);
`ifdef MIRFAK_WB_RAM_RANGE_CHECK_EN
        access("w_oor", 1'b0, 1'b1, 32'h4000_0040, 32'hA5A5_A5A5, 4'hF, 0, 1, 1, 32'h7654_3210);
        access("r_alias", 1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 1, 0, 1, 32'h5A5A_5A5A);
`else
        access("w_oor", 1'b0, 1'b1, 32'h4000_0040, 32'hA5A5_A5A5, 4'hF, 1, 0, 1, 32'h7654_3210);
        access("r_alias", 1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 1, 0, 1, 32'hA5A5_A5A5);
`endif

        // Reset while a write sits in WAIT
        base_ack_b = n_ack_b;
        addr  = 32'h8000_0030;
        wdat  = 32'h1111_1111;
        sel   = 4'hF;
        we    = 1'b1;
        stb   = 1'b1;
        cyc_b = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        stb   = 1'b0;
        cyc_b = 1'b0;
        rst_n = 1'b1;
        chk("mid_rst_dat_a", dat_a, 32'd0);
        chk("mid_rst_dat_b", dat_b, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rst_noack", 32'(n_ack_b - base_ack_b), 32'd0);
        chk("mid_rst_noerr", 32'(n_err_b), 32'd0);
        access("r_mid_rst", 1'b1, 1'b0, 32'h8000_0030, 32'h0, 4'hF, 1, 0, 4, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        #1;
`ifdef MIRFAK_WB_RAM_RANGE_CHECK_EN
        chk("tot_ack_a", 32'(n_ack_a), 32'd17);
        chk("tot_err_a", 32'(n_err_a), 32'd1);
`else
        chk("tot_ack_a", 32'(n_ack_a), 32'd18);
        chk("tot_err_a", 32'(n_err_a), 32'd0);
`endif
        chk("tot_ack_b", 32'(n_ack_b), 32'd4);
        chk("ack_err_excl", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
